// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_ALIGN_MASK     = 32'h0000_0003;
  localparam logic [XLEN-1:0] INSTR_BYTES          = 32'h0000_0004;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_e;

  // Payload handed to decode: fetched word together with the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_instr_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & INSTR_ALIGN_MASK) != '0;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: sequential PC+4, redirect target, or trap vector on a misaligned target.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misaligned_c
);

  logic [XLEN-1:0] pc_plus4;

  // Plain 32-bit add; wraps from the top of the address space to zero.
  assign pc_plus4 = pc + INSTR_BYTES;

  always_comb begin
    misaligned_c = 1'b0;
    next_pc_c    = pc_plus4;
    if (redirect_valid) begin
      misaligned_c = is_misaligned(redirect_target);
      next_pc_c    = misaligned_c ? TRAP_VECTOR : redirect_target;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the architectural PC and runs single-outstanding instruction fetch from imem to decode.
module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fault_valid,
  output logic [XLEN-1:0] fault_addr
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc_c;
  logic            misaligned_c;
  logic            redirect_en;
  logic            kill_q;
  logic            kill_d;
  logic            pc_load;
  logic            instr_load;
  fetch_instr_t    instr_q;
  logic            fault_valid_q;
  logic [XLEN-1:0] fault_addr_q;

  // Redirects are meaningless before the first fetch has been issued.
  assign redirect_en = redirect_valid && (state_q != BOOT);

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_next_sel (
    .pc              (pc_q),
    .redirect_valid  (redirect_en),
    .redirect_target (redirect_target),
    .next_pc_c       (next_pc_c),
    .misaligned_c    (misaligned_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ:  if (imem_ready) state_d = WAIT;
      WAIT: begin
        if (redirect_en) begin
          if (imem_rvalid) state_d = REQ;
        end else if (imem_rvalid) begin
          state_d = kill_q ? REQ : HOLD;
        end
      end
      HOLD: if (redirect_en || instr_ready) state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  // Kill marks the single in-flight response as stale after a redirect.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_load     = 1'b0;
    instr_load  = 1'b0;
    kill_d      = kill_q;
    case (state_q)
      BOOT: ;
      REQ: begin
        imem_req = 1'b1;
        pc_load  = redirect_en;
        if (redirect_en && imem_ready) kill_d = 1'b1;
      end
      WAIT: begin
        pc_load = redirect_en;
        if (imem_rvalid) begin
          kill_d     = 1'b0;
          instr_load = !kill_q && !redirect_en;
        end else if (redirect_en) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        pc_load     = redirect_en || instr_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_VECTOR;
      kill_q        <= 1'b0;
      instr_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      kill_q        <= kill_d;
      fault_valid_q <= redirect_en && misaligned_c;
      if (pc_load)    pc_q    <= next_pc_c;
      if (instr_load) instr_q <= '{pc: pc_q, word: imem_rdata};
      if (redirect_en && misaligned_c) fault_addr_q <= redirect_target;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q.word;
  assign instr_pc    = instr_q.pc;
  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a PC-stream reference model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fault_valid;
  logic [31:0] fault_addr;

  int errors = 0;
  int checks = 0;

  // imem responder state
  bit          resp_en = 1'b1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          lat_max = 0;
  bit          lat_rand = 1'b0;
  bit          spurious = 1'b0;
  int          overlap_cnt = 0;

  pc_fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fault_valid     (fault_valid),
    .fault_addr      (fault_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_resp();
    if (resp_en) begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_fn(pend_addr);
      end else if (!pend && spurious && $urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      end
    end
  endtask

  // One clock: capture handshakes, advance the responder, return just after the falling edge.
  task automatic clock_edge();
    bit          acc;
    bit          rv;
    logic [31:0] a;
    acc = imem_req && imem_ready;
    rv  = imem_rvalid;
    a   = imem_addr;
    @(posedge clk);
    if (resp_en) begin
      if (rv && pend && pend_cnt == 0) pend = 1'b0;
      else if (pend && pend_cnt > 0) pend_cnt--;
      if (acc) begin
        if (pend) overlap_cnt++;
        pend      = 1'b1;
        pend_addr = a;
        pend_cnt  = lat_rand ? int'($urandom_range(0, lat_max)) : lat_max;
      end
    end
    @(negedge clk);
    drive_resp();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    pend = 1'b0; resp_en = 1'b1; spurious = 1'b0; lat_max = 0; lat_rand = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== RV) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RV); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_ipc: got %h want 0", instr_pc); end
    checks++; if (fault_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid: got %b want 0", fault_valid); end
    checks++; if (fault_addr !== 32'h0) begin errors++; $display("FAIL reset_faddr: got %h want 0", fault_addr); end
    clock_edge();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RV) begin errors++; $display("FAIL boot_to_req: req %b addr %h want 1 %h", imem_req, imem_addr, RV); end
  endtask

  task automatic test_sequential();
    logic [31:0] accs[$];
    logic [31:0] pcs[$];
    logic [31:0] words[$];
    int first_acc;
    int first_val;
    first_acc = -1; first_val = -1;
    do_reset(); clock_edge();
    imem_ready = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (imem_req && imem_ready) begin accs.push_back(imem_addr); if (first_acc < 0) first_acc = c; end
      if (instr_valid) begin pcs.push_back(instr_pc); words.push_back(instr); if (first_val < 0) first_val = c; end
      clock_edge();
    end
    checks++;
    if (accs.size() < 3 || pcs.size() < 3) begin
      errors++; $display("FAIL seq_count: got %0d reqs %0d instrs want >=3", accs.size(), pcs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (accs[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, accs[i], 32'(4 * i)); end
        checks++; if (pcs[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pcs[i], 32'(4 * i)); end
        checks++; if (words[i] !== mem_fn(32'(4 * i))) begin errors++; $display("FAIL seq_word%0d: got %h want %h", i, words[i], mem_fn(32'(4 * i))); end
      end
    end
    checks++; if (first_val - first_acc != 2) begin errors++; $display("FAIL seq_latency: got %0d want 2", first_val - first_acc); end
    imem_ready = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    do_reset(); clock_edge();
    imem_ready = 1'b1; instr_ready = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 32'h4) && n < 20) begin clock_edge(); n++; end
    checks++; if (!(imem_req && imem_addr == 32'h4)) begin errors++; $display("FAIL stall_reach: addr %h req %b want 4 1", imem_addr, imem_req); end
    imem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      clock_edge();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_hold%0d: req %b addr %h want 1 4", c, imem_req, imem_addr); end
    end
    imem_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin clock_edge(); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin errors++; $display("FAIL stall_deliver: valid %b pc %h want 1 4", instr_valid, instr_pc); end
    imem_ready = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    int n;
    do_reset(); lat_max = 2; clock_edge();
    imem_ready = 1'b1; instr_ready = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_req: req %b addr %h want 1 0", imem_req, imem_addr); end
    clock_edge();
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h200;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait_req: got %b want 0", imem_req); end
    clock_edge();
    redirect_valid = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: instr_valid %b pc %h want 0", instr_valid, instr_pc); end
      clock_edge(); n++;
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rw_newaddr: req %b addr %h want 1 200", imem_req, imem_addr); end
    imem_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin clock_edge(); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_fn(32'h200)) begin
      errors++; $display("FAIL rw_deliver: valid %b pc %h word %h want 1 200 %h", instr_valid, instr_pc, instr, mem_fn(32'h200));
    end
    imem_ready = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_redirect_hold_fault();
    int n;
    do_reset(); clock_edge();
    imem_ready = 1'b1; instr_ready = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin clock_edge(); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL rh_hold: valid %b pc %h want 1 0", instr_valid, instr_pc); end
    redirect_valid = 1'b1; redirect_target = 32'h202; instr_ready = 1'b1;
    clock_edge();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    checks++; if (fault_valid !== 1'b1) begin errors++; $display("FAIL rh_fvalid: got %b want 1", fault_valid); end
    checks++; if (fault_addr !== 32'h202) begin errors++; $display("FAIL rh_faddr: got %h want 202", fault_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rh_drop: got %b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== TV) begin errors++; $display("FAIL rh_trap: req %b addr %h want 1 %h", imem_req, imem_addr, TV); end
    clock_edge();
    checks++; if (fault_valid !== 1'b0 || fault_addr !== 32'h202) begin errors++; $display("FAIL rh_pulse: fv %b fa %h want 0 202", fault_valid, fault_addr); end
    n = 0;
    while (!instr_valid && n < 20) begin clock_edge(); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== TV) begin errors++; $display("FAIL rh_deliver: valid %b pc %h want 1 %h", instr_valid, instr_pc, TV); end
    imem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    do_reset(); clock_edge();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    clock_edge();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || fault_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_req: req %b addr %h fv %b want 1 fffffffc 0", imem_req, imem_addr, fault_valid);
    end
    imem_ready = 1'b1; instr_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin clock_edge(); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== mem_fn(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_instr: valid %b pc %h word %h", instr_valid, instr_pc, instr);
    end
    clock_edge();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: req %b addr %h want 1 0", imem_req, imem_addr); end
    imem_ready = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_reset_midway();
    int n;
    do_reset(); clock_edge();
    resp_en = 1'b0; imem_ready = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_req: req %b addr %h want 1 0", imem_req, imem_addr); end
    clock_edge();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== RV || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rm_async: req %b addr %h iv %b want 0 %h 0", imem_req, imem_addr, instr_valid, RV);
    end
    clock_edge(); clock_edge();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_boot: req %b want 0", imem_req); end
    clock_edge();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_refetch: req %b addr %h want 1 0", imem_req, imem_addr); end
    clock_edge();
    imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rm_late: req %b addr %h iv %b want 1 0 0", imem_req, imem_addr, instr_valid);
    end
    resp_en = 1'b1; pend = 1'b0; imem_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin clock_edge(); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_fn(32'h0)) begin
      errors++; $display("FAIL rm_deliver: valid %b pc %h word %h want 1 0 %h", instr_valid, instr_pc, instr, mem_fn(32'h0));
    end
    imem_ready = 1'b0;
  endtask

  // Reference: expected PC advances by 4 per consumed instr; redirects replace it (trap if misaligned).
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_fa;
    logic [31:0] stall_addr;
    logic [31:0] r;
    logic [31:0] tgt;
    bit          exp_fv;
    bit          stall_prev;
    int          consumed;
    do_reset(); lat_max = 2; lat_rand = 1'b1; spurious = 1'b1; overlap_cnt = 0;
    clock_edge();
    exp_pc = RV; exp_fa = '0; exp_fv = 1'b0; stall_prev = 1'b0; stall_addr = '0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      checks++; if (fault_valid !== exp_fv) begin errors++; $display("FAIL rnd_fvalid c%0d: got %b want %b", c, fault_valid, exp_fv); end
      checks++; if (fault_addr !== exp_fa) begin errors++; $display("FAIL rnd_faddr c%0d: got %h want %h", c, fault_addr, exp_fa); end
      if (stall_prev) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== stall_addr) begin
          errors++; $display("FAIL rnd_stable c%0d: req %b addr %h want 1 %h", c, imem_req, imem_addr, stall_addr);
        end
      end
      if (imem_req) begin
        checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, exp_pc); end
      end
      if (instr_valid) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem_fn(exp_pc)) begin
          errors++; $display("FAIL rnd_instr c%0d: pc %h word %h want %h %h", c, instr_pc, instr, exp_pc, mem_fn(exp_pc));
        end
      end
      imem_ready  = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      r = $urandom;
      case ($urandom_range(0, 4))
        0:       tgt = {r[31:2], 2'b00};
        1:       tgt = r | 32'h1;
        2:       tgt = 32'hFFFF_FFF8;
        3:       tgt = {22'd0, r[9:2], 2'b00};
        default: tgt = {r[31:2], 2'b10};
      endcase
      redirect_target = tgt;
      exp_fv = 1'b0;
      if (redirect_valid) begin
        if (tgt[1:0] != 2'b00) begin exp_pc = TV; exp_fv = 1'b1; exp_fa = tgt; end
        else exp_pc = tgt;
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      stall_prev = imem_req && !imem_ready && !redirect_valid;
      stall_addr = imem_addr;
      clock_edge();
    end
    redirect_valid = 1'b0; imem_ready = 1'b0; instr_ready = 1'b0;
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL rnd_outstanding: got %0d overlaps want 0", overlap_cnt); end
    checks++; if (consumed < 50) begin errors++; $display("FAIL rnd_progress: got %0d consumed want >=50", consumed); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold_fault();
    test_wrap();
    test_reset_midway();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
